div_share_ctrl: RTL and testbench

- Round-robin arbiter and sequencer that shares one iterative divider among N requesters.
- The divider has a start/ack/complete interface: operands are sampled on start; complete stays high until ack or the next start.
- The block accepts one request at a time, drives the divider, and returns quotient and remainder to the owning requester.
- It holds the response until that requester acknowledges it.
- It sits between the accelerator front-ends and the shared divider instance.

---
 rtl/div_share_ctrl.sv | 153 +++++++++++++++
 tb/tb_div_share_ctrl.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// Round-robin sharing of one iterative divider among N requesters.
// Optional macro DIV_ZERO_BYPASS_EN: zero divisor returns all-ones quotient.
module div_share_ctrl #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   resp_valid,
  output logic [W-1:0]   resp_q,
  output logic [W-1:0]   resp_r,
  output logic           resp_err,
  input  logic [N-1:0]   resp_ack,
  output logic           div_start,
  output logic [W-1:0]   div_a,
  output logic [W-1:0]   div_b,
  output logic           div_ack,
  input  logic [W-1:0]   div_q,
  input  logic [W-1:0]   div_r,
  input  logic           div_complete
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [LW-1:0]   rr_last;
  logic [LW-1:0]   owner;
  logic [LW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [N-1:0]    gnt_oh;
  logic            first_wait;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    res_q;
  logic [W-1:0]    res_r;
  logic            err;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;

  // Scan downward so the nearest index after rr_last wins.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(rr_last) + k) % N;
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[LW-1:0];
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  assign sel_a = req_a[int'(gnt_idx)*W +: W];
  assign sel_b = req_b[int'(gnt_idx)*W +: W];

  assign req_ready = (state == IDLE && !rst)
                     ? gnt_oh : '0;

  // The first WAIT cycle may still show a stale complete flag.
  assign div_ack = (state == WAIT) && !first_wait
                   && div_complete && !rst;

  assign div_a    = op_a;
  assign div_b    = op_b;
  assign resp_q   = res_q;
  assign resp_r   = res_r;
  assign resp_err = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_last    <= LW'(N - 1);
      owner      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      res_q      <= '0;
      res_r      <= '0;
      err        <= 1'b0;
      div_start  <= 1'b0;
      resp_valid <= '0;
      first_wait <= 1'b0;
    end else begin
      div_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            owner   <= gnt_idx;
            rr_last <= gnt_idx;
            op_a    <= sel_a;
            op_b    <= sel_b;
            if (sel_b == '0) begin
              state      <= RESP;
              resp_valid <= gnt_oh;
`ifdef DIV_ZERO_BYPASS_EN
              res_q <= '1;
              res_r <= sel_a;
              err   <= 1'b0;
`else
              res_q <= '0;
              res_r <= '0;
              err   <= 1'b1;
`endif
            end else begin
              state     <= START;
              div_start <= 1'b1;
            end
          end
        end
        START: begin
          state      <= WAIT;
          first_wait <= 1'b1;
        end
        WAIT: begin
          first_wait <= 1'b0;
          if (!first_wait && div_complete) begin
            res_q        <= div_q;
            res_r        <= div_r;
            err          <= 1'b0;
            resp_valid   <= '0;
            resp_valid[owner] <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (resp_ack[owner]) begin
            resp_valid <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl with a behavioural divider
// and an arithmetic reference for grants and results.
module tb_div_share_ctrl;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_q;
  logic [W-1:0]   resp_r;
  logic           resp_err;
  logic [N-1:0]   resp_ack = '0;
  logic           div_start;
  logic [W-1:0]   div_a;
  logic [W-1:0]   div_b;
  logic           div_ack;
  logic [W-1:0]   div_q = '0;
  logic [W-1:0]   div_r = '0;
  logic           div_complete = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int n_ack = 0;
  int n_zero_start = 0;
  int start_cyc = -1;
  int ack_cyc = -1;
  int n_ready[N];

  div_share_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_q(resp_q),
    .resp_r(resp_r), .resp_err(resp_err),
    .resp_ack(resp_ack),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_ack(div_ack), .div_q(div_q), .div_r(div_r),
    .div_complete(div_complete)
  );

  always #5 clk = ~clk;

  // Behavioural divider with random latency.
  logic [W-1:0] m_a, m_b;
  int           m_cnt;
  logic         m_busy = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      div_complete <= 1'b0;
      m_busy       <= 1'b0;
    end else if (div_start) begin
      m_a          <= div_a;
      m_b          <= div_b;
      m_busy       <= 1'b1;
      m_cnt        <= int'($urandom_range(1, 6));
      div_complete <= 1'b0;
    end else if (div_ack) begin
      div_complete <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy       <= 1'b0;
        div_complete <= 1'b1;
        if (m_b != 0) begin
          div_q <= m_a / m_b;
          div_r <= m_a % m_b;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  initial for (int i = 0; i < N; i++) n_ready[i] = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (div_start) begin
        n_start++;
        start_cyc = cyc;
        if (div_b == '0) n_zero_start++;
      end
      if (div_ack) begin
        n_ack++;
        ack_cyc = cyc;
      end
      for (int i = 0; i < N; i++)
        if (req_ready[i]) n_ready[i]++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int i, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_ready(input int i, output bit ok, output int t);
    ok = 1'b0;
    t = -1;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (req_ready[i]) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_resp(input int i, output bit ok, output int t,
                           output logic [W-1:0] q,
                           output logic [W-1:0] r,
                           output logic e);
    ok = 1'b0;
    t = -1;
    q = '0;
    r = '0;
    e = 1'b0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (resp_valid[i]) begin
        ok = 1'b1;
        t = cyc;
        q = resp_q;
        r = resp_r;
        e = resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic give_ack(input int i);
    resp_ack[i] = 1'b1;
    @(negedge clk);
    resp_ack[i] = 1'b0;
  endtask

  task automatic xact(input int i, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit do_ack,
                      output bit ok, output logic [W-1:0] q,
                      output logic [W-1:0] r, output logic e,
                      output int ta, output int tr);
    bit okr, okp;
    drive(i, a, b);
    wait_ready(i, okr, ta);
    @(negedge clk);
    req_valid[i] = 1'b0;
    wait_resp(i, okp, tr, q, r, e);
    ok = okr && okp;
    if (okp && do_ack) give_ack(i);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== '0 || resp_valid !== '0) begin
      errors++;
      $display("FAIL reset_hs got %b/%b want 0/0", req_ready, resp_valid);
    end
    checks++;
    if (resp_q !== '0 || resp_r !== '0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp got %h/%h/%b want 0", resp_q, resp_r, resp_err);
    end
    checks++;
    if (div_start !== 1'b0 || div_ack !== 1'b0 ||
        div_a !== '0 || div_b !== '0) begin
      errors++;
      $display("FAIL reset_div got %b/%b/%h/%h want 0",
               div_start, div_ack, div_a, div_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    logic [W-1:0] q, r;
    logic e;
    int ta, tr, s0, a0, r0;
    s0 = n_start;
    a0 = n_ack;
    r0 = n_ready[0];
    xact(0, 100, 7, 1'b1, ok, q, r, e, ta, tr);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || q !== 14 || r !== 2 || e !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got ok=%0d %0d/%0d/%b want 14/2/0", ok, q, r, e);
    end
    checks++;
    if (n_ready[0] - r0 != 1) begin
      errors++;
      $display("FAIL basic_ready_cycles got %0d want 1", n_ready[0] - r0);
    end
    checks++;
    if (n_start - s0 != 1 || n_ack - a0 != 1) begin
      errors++;
      $display("FAIL basic_pulses got start=%0d ack=%0d want 1/1",
               n_start - s0, n_ack - a0);
    end
    checks++;
    if (start_cyc != ta + 1) begin
      errors++;
      $display("FAIL basic_start_lat got %0d want %0d", start_cyc, ta + 1);
    end
    checks++;
    if (tr != ack_cyc + 1 || tr < ta + 4) begin
      errors++;
      $display("FAIL basic_resp_lat got %0d want %0d", tr, ack_cyc + 1);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] ta_[N], tb_[N], eq[N], er[N];
    logic [N-1:0] oh;
    logic [W-1:0] q, r;
    logic e;
    bit ok;
    int t, exp_g, last;
    ta_ = '{1000, 999, 50, 7};
    tb_ = '{10, 3, 7, 50};
    eq  = '{100, 333, 7, 0};
    er  = '{0, 0, 1, 7};
    pulse_reset();
    for (int i = 0; i < N; i++) drive(i, ta_[i], tb_[i]);
    last = N - 1;
    for (int n = 0; n < 5; n++) begin
      exp_g = (last + 1) % N;
      last = exp_g;
      oh = '0;
      oh[exp_g] = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
        #1;
        if (req_ready != '0) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      checks++;
      if (!ok || req_ready !== oh) begin
        errors++;
        $display("FAIL rr_grant%0d got %b want %b", n, req_ready, oh);
      end
      @(negedge clk);
      if (n == 4) req_valid = '0;
      wait_resp(exp_g, ok, t, q, r, e);
      checks++;
      if (!ok || resp_valid !== oh || q !== eq[exp_g] ||
          r !== er[exp_g] || e !== 1'b0) begin
        errors++;
        $display("FAIL rr_resp%0d got %b %0d/%0d/%b want %b %0d/%0d/0",
                 n, resp_valid, q, r, e, oh, eq[exp_g], er[exp_g]);
      end
      if (ok) give_ack(exp_g);
    end
  endtask

  task automatic test_hold();
    bit ok;
    logic [W-1:0] q, r;
    logic e;
    int ta, tr, s0, bad;
    xact(0, 1000, 10, 1'b0, ok, q, r, e, ta, tr);
    checks++;
    if (!ok || q !== 100 || r !== 0) begin
      errors++;
      $display("FAIL hold_first got %0d/%0d want 100/0", q, r);
    end
    drive(1, 64, 8);
    resp_ack[1] = 1'b1;
    s0 = n_start;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid !== 4'b0001 || resp_q !== 100 ||
          resp_r !== 0 || req_ready !== '0) bad++;
    end
    resp_ack[1] = 1'b0;
    checks++;
    if (bad != 0 || n_start != s0) begin
      errors++;
      $display("FAIL hold_stable got bad=%0d starts=%0d want 0/0",
               bad, n_start - s0);
    end
    give_ack(0);
    #1;
    checks++;
    if (req_ready !== 4'b0010 || resp_valid !== '0) begin
      errors++;
      $display("FAIL hold_next_grant got %b/%b want 0010/0000",
               req_ready, resp_valid);
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_resp(1, ok, tr, q, r, e);
    checks++;
    if (!ok || q !== 8 || r !== 0 || e !== 1'b0) begin
      errors++;
      $display("FAIL hold_req1 got %0d/%0d/%b want 8/0/0", q, r, e);
    end
    if (ok) give_ack(1);
  endtask

  task automatic test_zero();
    bit ok;
    logic [W-1:0] q, r, eq, er;
    logic e, ee;
    int ta, tr, s0, z0;
`ifdef DIV_ZERO_BYPASS_EN
    eq = 32'hFFFF_FFFF;
    er = 55;
    ee = 1'b0;
`else
    eq = 0;
    er = 0;
    ee = 1'b1;
`endif
    s0 = n_start;
    z0 = n_zero_start;
    xact(2, 55, 0, 1'b1, ok, q, r, e, ta, tr);
    @(negedge clk);
    checks++;
    if (!ok || q !== eq || r !== er || e !== ee) begin
      errors++;
      $display("FAIL zero_result got %h/%0d/%b want %h/%0d/%b",
               q, r, e, eq, er, ee);
    end
    checks++;
    if (tr != ta + 1) begin
      errors++;
      $display("FAIL zero_latency got %0d want %0d", tr, ta + 1);
    end
    checks++;
    if (n_start != s0 || n_zero_start != z0) begin
      errors++;
      $display("FAIL zero_no_start got %0d want 0", n_start - s0);
    end
  endtask

  task automatic test_boundary();
    bit ok;
    logic [W-1:0] q, r;
    logic e;
    int ta, tr;
    xact(3, 3, 9, 1'b1, ok, q, r, e, ta, tr);
    checks++;
    if (!ok || q !== 0 || r !== 3 || e !== 1'b0) begin
      errors++;
      $display("FAIL small_a got %0d/%0d/%b want 0/3/0", q, r, e);
    end
    xact(1, 32'hFFFF_FFFF, 1, 1'b1, ok, q, r, e, ta, tr);
    checks++;
    if (!ok || q !== 32'hFFFF_FFFF || r !== 0 || e !== 1'b0) begin
      errors++;
      $display("FAIL max_a got %h/%0d/%b want ffffffff/0/0", q, r, e);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [W-1:0] q, r;
    logic e;
    int ta, tr, bad;
    drive(0, 1000, 3);
    wait_ready(0, ok, ta);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || resp_valid !== '0 || resp_q !== '0 ||
        resp_r !== '0 || resp_err !== 1'b0 || div_start !== 1'b0 ||
        div_ack !== 1'b0 || div_a !== '0 || div_b !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got rv=%b q=%h a=%h b=%h want 0",
               resp_valid, resp_q, div_a, div_b);
    end
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp_valid !== '0 || div_start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_no_resp got %0d want 0", bad);
    end
    xact(1, 81, 9, 1'b1, ok, q, r, e, ta, tr);
    checks++;
    if (!ok || q !== 9 || r !== 0 || e !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after got %0d/%0d/%b want 9/0/0", q, r, e);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] pend, oh;
    logic [W-1:0] pa[N], pb[N], q, r, eq, er;
    logic e, ee;
    bit ok;
    int last, g, t;
    pulse_reset();
    pend = '0;
    last = N - 1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1 || pend == '0)) begin
          pa[i] = ($urandom_range(0, 1) == 1)
                  ? W'($urandom) : W'($urandom_range(0, 200));
          case ($urandom_range(0, 5))
            0:       pb[i] = 0;
            1, 2:    pb[i] = W'($urandom_range(1, 20));
            default: pb[i] = W'($urandom);
          endcase
          pend[i] = 1'b1;
          drive(i, pa[i], pb[i]);
        end
      end
      g = -1;
      for (int k = 1; k <= N && g < 0; k++)
        if (pend[(last + k) % N]) g = (last + k) % N;
      last = g;
      oh = '0;
      oh[g] = 1'b1;
      wait_ready(g, ok, t);
      checks++;
      if (!ok || req_ready !== oh) begin
        errors++;
        $display("FAIL rand_grant%0d got %b want %b", n, req_ready, oh);
      end
      @(negedge clk);
      pend[g] = 1'b0;
      req_valid[g] = 1'b0;
      if (pb[g] != 0) begin
        eq = pa[g] / pb[g];
        er = pa[g] % pb[g];
        ee = 1'b0;
      end else begin
`ifdef DIV_ZERO_BYPASS_EN
        eq = '1;
        er = pa[g];
        ee = 1'b0;
`else
        eq = '0;
        er = '0;
        ee = 1'b1;
`endif
      end
      wait_resp(g, ok, t, q, r, e);
      checks++;
      if (!ok || resp_valid !== oh || q !== eq || r !== er || e !== ee) begin
        errors++;
        $display("FAIL rand_resp%0d got %b %h/%h/%b want %b %h/%h/%b",
                 n, resp_valid, q, r, e, oh, eq, er, ee);
      end
      if (ok) give_ack(g);
    end
    req_valid = '0;
    checks++;
    if (n_zero_start != 0) begin
      errors++;
      $display("FAIL rand_zero_start got %0d want 0", n_zero_start);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_hold();
    test_zero();
    test_boundary();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
